// File: rtl/requant_pipe.sv
`default_nettype none
// ============================================================================
// Module      : requant_pipe
// Description : Four-stage int8-style requantizer for conv1d accumulators:
//               bias add, saturating rounding doubling high multiply,
//               rounding right shift, output offset, activation clamp.
// Revision    : 1.0 - initial release
// ============================================================================
module requant_pipe #(
    parameter int INT32_SIZE = 32,
    parameter int LATENCY    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic signed [INT32_SIZE-1:0] acc,
    input  logic signed [INT32_SIZE-1:0] bias,
    input  logic signed [INT32_SIZE-1:0] output_multiplier,
    input  logic signed [INT32_SIZE-1:0] output_shift,
    input  logic signed [INT32_SIZE-1:0] output_activation_min,
    input  logic signed [INT32_SIZE-1:0] output_activation_max,
    input  logic signed [INT32_SIZE-1:0] output_offset,
    output logic signed [INT32_SIZE-1:0] ret,
    output logic                         ret_valid,
    output logic                         busy
);

    localparam int c_W   = INT32_SIZE;
    localparam int c_PW  = 2 * INT32_SIZE;
    localparam int c_SHW = $clog2(INT32_SIZE);

    localparam logic signed [c_W-1:0]  c_ZERO     = '0;
    localparam logic signed [c_W-1:0]  c_MIN      = {1'b1, {(c_W-1){1'b0}}};
    localparam logic signed [c_W-1:0]  c_MAX      = {1'b0, {(c_W-1){1'b1}}};
    localparam logic signed [c_W-1:0]  c_SHMAX    = c_W - 1;
    localparam logic        [c_W-1:0]  c_ONE_W    = {{(c_W-1){1'b0}}, 1'b1};
    localparam logic signed [c_PW-1:0] c_ONE_P    = {{(c_PW-1){1'b0}}, 1'b1};
    localparam logic signed [c_PW-1:0] c_NUDGE_P  = {{(c_W+1){1'b0}}, 1'b1, {(c_W-2){1'b0}}};
    localparam logic signed [c_PW-1:0] c_NUDGE_N  = c_ONE_P - c_NUDGE_P;
    localparam logic signed [c_PW-1:0] c_TRUNC_ADJ = {{(c_W+1){1'b0}}, {(c_W-1){1'b1}}};

    // ------------------------------------------------------------------
    // Valid shift register; data stages below are captured every cycle
    // and qualified only by these bits.
    // ------------------------------------------------------------------
    logic [LATENCY-1:0] r_vld;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[LATENCY-2:0], start};
        end
    end

    assign ret_valid = r_vld[LATENCY-1];
    assign busy      = |r_vld;

    // ------------------------------------------------------------------
    // S1: bias add and shift split
    // ------------------------------------------------------------------
    logic signed [c_W-1:0]   w_x;
    logic signed [c_W-1:0]   w_neg_shift;
    logic signed [c_W-1:0]   w_y;
    logic        [c_SHW-1:0] w_ls;
    logic        [c_SHW-1:0] w_rs;

    assign w_x         = acc + bias;
    assign w_neg_shift = -output_shift;

    // Range tests use signed compares so that shift = most-negative never
    // goes through the overflowing negation.
    always_comb begin
        w_ls = '0;
        w_rs = '0;
        if (output_shift > c_ZERO) begin
            if (output_shift > c_SHMAX) w_ls = c_SHMAX[c_SHW-1:0];
            else                        w_ls = output_shift[c_SHW-1:0];
        end else begin
            if (output_shift < -c_SHMAX) w_rs = c_SHMAX[c_SHW-1:0];
            else                         w_rs = w_neg_shift[c_SHW-1:0];
        end
    end

    assign w_y = w_x << w_ls;

    logic signed [c_W-1:0]   r_s1_y;
    logic signed [c_W-1:0]   r_s1_mult;
    logic        [c_SHW-1:0] r_s1_rs;
    logic signed [c_W-1:0]   r_s1_off;
    logic signed [c_W-1:0]   r_s1_min;
    logic signed [c_W-1:0]   r_s1_max;

    always_ff @(posedge clk) begin
        r_s1_y    <= w_y;
        r_s1_mult <= output_multiplier;
        r_s1_rs   <= w_rs;
        r_s1_off  <= output_offset;
        r_s1_min  <= output_activation_min;
        r_s1_max  <= output_activation_max;
    end

    // ------------------------------------------------------------------
    // S2: full-width signed product and saturation detect
    // ------------------------------------------------------------------
    logic signed [c_PW-1:0] w_ab;
    logic                   w_sat;

    assign w_ab  = $signed({{c_W{r_s1_y[c_W-1]}}, r_s1_y} *
                           {{c_W{r_s1_mult[c_W-1]}}, r_s1_mult});
    assign w_sat = (r_s1_y == c_MIN) && (r_s1_mult == c_MIN);

    logic signed [c_PW-1:0]  r_s2_ab;
    logic                    r_s2_sat;
    logic        [c_SHW-1:0] r_s2_rs;
    logic signed [c_W-1:0]   r_s2_off;
    logic signed [c_W-1:0]   r_s2_min;
    logic signed [c_W-1:0]   r_s2_max;

    always_ff @(posedge clk) begin
        r_s2_ab  <= w_ab;
        r_s2_sat <= w_sat;
        r_s2_rs  <= r_s1_rs;
        r_s2_off <= r_s1_off;
        r_s2_min <= r_s1_min;
        r_s2_max <= r_s1_max;
    end

    // ------------------------------------------------------------------
    // S3: nudge and divide by 2^31 with truncation toward zero; negative
    // sums are biased by 2^31-1 so the arithmetic shift rounds up.
    // ------------------------------------------------------------------
    logic signed [c_PW-1:0] w_sum;
    logic signed [c_PW-1:0] w_adj;
    logic signed [c_W-1:0]  w_h;

    assign w_sum = r_s2_ab + (r_s2_ab[c_PW-1] ? c_NUDGE_N : c_NUDGE_P);
    assign w_adj = w_sum[c_PW-1] ? (w_sum + c_TRUNC_ADJ) : w_sum;
    assign w_h   = r_s2_sat ? c_MAX : $signed(w_adj[c_PW-2:c_W-1]);

    logic signed [c_W-1:0]   r_s3_h;
    logic        [c_SHW-1:0] r_s3_rs;
    logic signed [c_W-1:0]   r_s3_off;
    logic signed [c_W-1:0]   r_s3_min;
    logic signed [c_W-1:0]   r_s3_max;

    always_ff @(posedge clk) begin
        r_s3_h   <= w_h;
        r_s3_rs  <= r_s2_rs;
        r_s3_off <= r_s2_off;
        r_s3_min <= r_s2_min;
        r_s3_max <= r_s2_max;
    end

    // ------------------------------------------------------------------
    // S4: rounding right shift, offset in c_W+1 bits, clamp max then min
    // ------------------------------------------------------------------
    logic        [c_W-1:0] w_mask;
    logic        [c_W-1:0] w_rem;
    logic        [c_W-1:0] w_thr;
    logic                  w_round;
    logic signed [c_W-1:0] w_z;
    logic signed [c_W:0]   w_o;
    logic signed [c_W:0]   w_min_x;
    logic signed [c_W:0]   w_max_x;
    logic signed [c_W:0]   w_c1;
    logic signed [c_W:0]   w_c2;

    assign w_mask  = (c_ONE_W << r_s3_rs) - c_ONE_W;
    assign w_rem   = r_s3_h & w_mask;
    assign w_thr   = (w_mask >> 1) + {{(c_W-1){1'b0}}, r_s3_h[c_W-1]};
    assign w_round = (w_rem > w_thr);
    assign w_z     = (r_s3_h >>> r_s3_rs) + $signed({{(c_W-1){1'b0}}, w_round});
    assign w_o     = $signed({w_z[c_W-1], w_z} + {r_s3_off[c_W-1], r_s3_off});
    assign w_min_x = $signed({r_s3_min[c_W-1], r_s3_min});
    assign w_max_x = $signed({r_s3_max[c_W-1], r_s3_max});
    assign w_c1    = (w_o > w_max_x) ? w_max_x : w_o;
    assign w_c2    = (w_c1 < w_min_x) ? w_min_x : w_c1;

    always_ff @(posedge clk) begin
        if (reset) begin
            ret <= '0;
        end else if (r_vld[LATENCY-2]) begin
            ret <= w_c2[c_W-1:0];
        end
    end

    // Bits that are provably redundant after truncation and clamping.
    logic w_unused;
    assign w_unused = ^{w_adj[c_PW-1], w_adj[c_W-2:0], w_c2[c_W]};

endmodule
`default_nettype wire
